// File: rtl/popcount_frame_accum.sv
// popcount_frame_accum
//   Accumulates the population count of every accepted WIDTH-bit word in a
//   frame (terminated by in_last) and emits one result per frame: total ones,
//   accepted beat count and a saturation flag. Both accumulators clamp at
//   all-ones and never wrap.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data/in_last valid this cycle
//   in_ready   block accepts a beat (high while accumulating)
//   in_data    WIDTH-bit word whose set bits are counted
//   in_last    accepted beat ends the frame
//   out_valid  frame result available
//   out_ready  downstream consumes the result
//   out_count  total ones in the frame (saturating)
//   out_beats  accepted beats in the frame (saturating)
//   out_sat    either count saturated during the frame
module popcount_frame_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_sat
);

  localparam logic [0:0]   S_ACCUM = 1'b0;
  localparam logic [0:0]   S_DONE  = 1'b1;
  localparam int unsigned  W_U     = WIDTH;
  localparam logic [CNT_W:0] ONE   = {{CNT_W{1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_count_q, acc_count_d;
  logic [CNT_W-1:0] acc_beats_q, acc_beats_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             out_sat_q, out_sat_d;

  logic [CNT_W:0]   pc;
  logic [CNT_W:0]   sum_count;
  logic [CNT_W:0]   sum_beats;
  logic [CNT_W-1:0] next_count;
  logic [CNT_W-1:0] next_beats;
  logic             next_sat;
  logic             xfer;

  // Population count of the incoming word, zero-extended to CNT_W+1 bits.
  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < W_U; i++) begin
      pc = pc + {{CNT_W{1'b0}}, in_data[i]};
    end
  end

  // The extra MSB of each sum is the clamp indicator; the count cannot
  // overflow CNT_W+1 bits because pc itself fits in CNT_W bits.
  always_comb begin
    sum_count  = {1'b0, acc_count_q} + pc;
    sum_beats  = {1'b0, acc_beats_q} + ONE;
    next_count = sum_count[CNT_W] ? '1 : sum_count[CNT_W-1:0];
    next_beats = sum_beats[CNT_W] ? '1 : sum_beats[CNT_W-1:0];
    next_sat   = sat_q | sum_count[CNT_W] | sum_beats[CNT_W];
  end

  assign in_ready = (state_q == S_ACCUM);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    acc_count_d = acc_count_q;
    acc_beats_d = acc_beats_q;
    sat_d       = sat_q;
    out_count_d = out_count_q;
    out_beats_d = out_beats_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      S_ACCUM: begin
        if (xfer) begin
          if (in_last) begin
            out_count_d = next_count;
            out_beats_d = next_beats;
            out_sat_d   = next_sat;
            acc_count_d = '0;
            acc_beats_d = '0;
            sat_d       = 1'b0;
            state_d     = S_DONE;
          end else begin
            acc_count_d = next_count;
            acc_beats_d = next_beats;
            sat_d       = next_sat;
          end
        end
      end
      default: begin
        if (out_ready) begin
          state_d = S_ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACCUM;
      acc_count_q <= '0;
      acc_beats_q <= '0;
      sat_q       <= 1'b0;
      out_count_q <= '0;
      out_beats_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_count_q <= acc_count_d;
      acc_beats_q <= acc_beats_d;
      sat_q       <= sat_d;
      out_count_q <= out_count_d;
      out_beats_q <= out_beats_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // out_valid is exactly "in DONE", so it is decoded from the state register
  // rather than kept as a separate flop.
  assign out_valid = (state_q == S_DONE);
  assign out_count = out_count_q;
  assign out_beats = out_beats_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Directed bench for popcount_frame_accum: three builds (8/16, 8/4, 1/16)
// driven from one linear sequence, each result checked by an immediate
// assertion against a hand-computed value.
module tb_popcount_frame_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Build A: WIDTH=8, CNT_W=16
  logic        a_in_valid = 1'b0, a_in_ready, a_in_last = 1'b0;
  logic [7:0]  a_in_data = '0;
  logic        a_out_valid, a_out_ready = 1'b0, a_out_sat;
  logic [15:0] a_out_count, a_out_beats;

  // Build B: WIDTH=8, CNT_W=4
  logic        b_in_valid = 1'b0, b_in_ready, b_in_last = 1'b0;
  logic [7:0]  b_in_data = '0;
  logic        b_out_valid, b_out_ready = 1'b0, b_out_sat;
  logic [3:0]  b_out_count, b_out_beats;

  // Build C: WIDTH=1, CNT_W=16
  logic        c_in_valid = 1'b0, c_in_ready, c_in_last = 1'b0;
  logic [0:0]  c_in_data = '0;
  logic        c_out_valid, c_out_ready = 1'b0, c_out_sat;
  logic [15:0] c_out_count, c_out_beats;

  popcount_frame_accum #(.WIDTH(8), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_count(a_out_count), .out_beats(a_out_beats), .out_sat(a_out_sat)
  );

  popcount_frame_accum #(.WIDTH(8), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_count(b_out_count), .out_beats(b_out_beats), .out_sat(b_out_sat)
  );

  popcount_frame_accum #(.WIDTH(1), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_last(c_in_last),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_count(c_out_count), .out_beats(c_out_beats), .out_sat(c_out_sat)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_beat(input logic [7:0] d, input logic last);
    a_in_data = d; a_in_last = last; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic b_beat(input logic [7:0] d, input logic last);
    b_in_data = d; b_in_last = last; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic c_beat(input logic d, input logic last);
    c_in_data = d; c_in_last = last; c_in_valid = 1'b1;
    tick();
    c_in_valid = 1'b0; c_in_last = 1'b0;
  endtask

  task automatic a_consume();
    a_out_ready = 1'b1; tick(); a_out_ready = 1'b0;
  endtask

  task automatic b_consume();
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
  endtask

  task automatic c_consume();
    c_out_ready = 1'b1; tick(); c_out_ready = 1'b0;
  endtask

  logic       c_bits [4];
  logic [7:0] c_ref;

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready",  a_in_ready,  1);
    check("rst_out_count", a_out_count, 0);
    check("rst_out_beats", a_out_beats, 0);
    check("rst_out_sat",   a_out_sat,   0);

    // Reset mid-frame discards the partial frame
    a_beat(8'h0F, 1'b0);
    a_beat(8'h03, 1'b0);
    check("midrst_no_out", a_out_valid, 0);
    rst = 1'b1; #2; rst = 1'b0;
    check("midrst_valid", a_out_valid, 0);
    check("midrst_ready", a_in_ready,  1);
    a_beat(8'h01, 1'b1);
    check("midrst_f_valid", a_out_valid, 1);
    check("midrst_f_count", a_out_count, 1);
    check("midrst_f_beats", a_out_beats, 1);
    check("midrst_f_sat",   a_out_sat,   0);
    a_consume();
    check("midrst_consumed", a_out_valid, 0);

    // Single beat 8'hFF
    a_beat(8'hFF, 1'b1);
    check("single_valid", a_out_valid, 1);
    check("single_count", a_out_count, 8);
    check("single_beats", a_out_beats, 1);
    check("single_ready", a_in_ready,  0);
    tick();
    check("single_hold_valid", a_out_valid, 1);
    check("single_hold_ready", a_in_ready,  0);
    a_consume();
    check("single_done_valid", a_out_valid, 0);
    check("single_done_ready", a_in_ready,  1);

    // Multi-beat with idle gaps: 4 + 1 + 8
    a_beat(8'h0F, 1'b0);
    tick(); tick();
    a_beat(8'h01, 1'b0);
    tick(); tick();
    check("multi_no_early", a_out_valid, 0);
    a_beat(8'hFF, 1'b1);
    check("multi_valid", a_out_valid, 1);
    check("multi_count", a_out_count, 13);
    check("multi_beats", a_out_beats, 3);
    check("multi_sat",   a_out_sat,   0);
    a_consume();

    // Backpressure; upstream offers a beat while DONE which must be ignored
    a_beat(8'hAA, 1'b1);
    a_in_data = 8'hFF; a_in_last = 1'b0; a_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", a_out_valid, 1);
      check("bp_count", a_out_count, 4);
      check("bp_beats", a_out_beats, 1);
      check("bp_ready", a_in_ready,  0);
      tick();
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0; a_in_valid = 1'b0;
    check("bp_release_valid", a_out_valid, 0);
    check("bp_release_ready", a_in_ready,  1);
    check("bp_data_kept",     a_out_count, 4);
    a_beat(8'h01, 1'b1);
    check("bp_next_count", a_out_count, 1);
    check("bp_next_beats", a_out_beats, 1);
    a_consume();

    // Zero-ones frame
    a_beat(8'h00, 1'b1);
    check("zero_valid", a_out_valid, 1);
    check("zero_count", a_out_count, 0);
    check("zero_beats", a_out_beats, 1);
    a_consume();

    // Count saturation, CNT_W=4
    b_beat(8'hFF, 1'b0);
    b_beat(8'hFF, 1'b1);
    check("sat_valid", b_out_valid, 1);
    check("sat_count", b_out_count, 15);
    check("sat_beats", b_out_beats, 2);
    check("sat_flag",  b_out_sat,   1);
    b_consume();
    b_beat(8'h01, 1'b1);
    check("sat_clr_count", b_out_count, 1);
    check("sat_clr_beats", b_out_beats, 1);
    check("sat_clr_flag",  b_out_sat,   0);
    b_consume();

    // Clamp sticks after further adds: 8 + 8 + 1 -> 15
    b_beat(8'hFF, 1'b0);
    b_beat(8'hFF, 1'b0);
    b_beat(8'h01, 1'b1);
    check("sat_stick_count", b_out_count, 15);
    check("sat_stick_flag",  b_out_sat,   1);
    b_consume();

    // Beat-count saturation: 17 zero beats -> beats clamp at 15
    for (int k = 0; k < 16; k++) b_beat(8'h00, 1'b0);
    b_beat(8'h00, 1'b1);
    check("bsat_count", b_out_count, 0);
    check("bsat_beats", b_out_beats, 15);
    check("bsat_flag",  b_out_sat,   1);
    b_consume();

    // WIDTH=1 build: 1,0,1,1
    c_bits[0] = 1'b1; c_bits[1] = 1'b0; c_bits[2] = 1'b1; c_bits[3] = 1'b1;
    c_ref = '0;
    for (int k = 0; k < 4; k++) begin
      c_ref = c_ref + 8'($countones(c_bits[k]));
      c_beat(c_bits[k], k == 3);
    end
    check("w1_ref",   {24'd0, c_ref}, 3);
    check("w1_valid", c_out_valid, 1);
    check("w1_count", c_out_count, {24'd0, c_ref});
    check("w1_beats", c_out_beats, 4);
    check("w1_sat",   c_out_sat,   0);
    c_consume();

    // WIDTH=1 second frame: 0,1 -> 1 one, 2 beats
    c_bits[0] = 1'b0; c_bits[1] = 1'b1;
    c_ref = '0;
    for (int k = 0; k < 2; k++) begin
      c_ref = c_ref + 8'($countones(c_bits[k]));
      c_beat(c_bits[k], k == 1);
    end
    check("w1b_count", c_out_count, {24'd0, c_ref});
    check("w1b_beats", c_out_beats, 2);
    c_consume();
    check("w1b_consumed", c_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/popcount_frame_accum.md
Name: popcount_frame_accum

Overview:
- Streaming consumer of population counts: accepts WIDTH-bit words over a valid/ready handshake and sums the set bits of every word in a frame. A frame is terminated by in_last.
- Emits one result per frame: total ones, beat count and a saturation flag, held on a valid/ready output port.
- Sits directly downstream of the combinational $countones stage and is the sequential user of that stage's result.
- Serves as a synthesis/formal unit target in the same test suite.

Parameters:
- WIDTH, 8, data word width in bits; legal range >= 1, and WIDTH = 1 must work.
- CNT_W, 16, width of the count and beat accumulators; must satisfy CNT_W >= $clog2(WIDTH+1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data/in_last are valid this cycle.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  data word whose set bits are counted.
- in_last  input  1  the accepted beat is the last of its frame.
- out_valid  output  1  frame result is available.
- out_ready  input  1  downstream consumes the result.
- out_count  output  CNT_W  total ones in the frame, saturating.
- out_beats  output  CNT_W  number of accepted beats in the frame, saturating.
- out_sat  output  1  out_count or out_beats saturated during the frame.

Behaviour:
- States: ACCUM and DONE. Reset enters ACCUM.
- Asynchronous reset: state=ACCUM, acc_count=0, acc_beats=0, sat=0, out_valid=0, out_count=0, out_beats=0, out_sat=0. Reset asserted mid-frame discards the partial frame with no output.
- Handshake: a transfer occurs on a rising edge where valid && ready. Data is sampled only on a transfer.
- in_ready=1 in ACCUM and 0 in DONE. This gives exactly one bubble cycle minimum between frames.
- pc = sum of in_data bits, zero-extended to CNT_W+1 bits.
- ACCUM, transfer without in_last:
  - acc_count <= min(acc_count+pc, 2^CNT_W-1).
  - acc_beats <= min(acc_beats+1, 2^CNT_W-1).
  - sat <= sat | either clamp occurred.
- ACCUM, transfer with in_last:
  - Same arithmetic, but the results are written to out_count/out_beats/out_sat instead.
  - out_valid <= 1, state <= DONE.
  - Accumulators and sat clear to 0.
  - Latency: out_valid is high in the cycle after the last-beat transfer.
- ACCUM, no transfer (in_valid=0): nothing changes. Idle gaps inside a frame are legal.
- DONE: out_count, out_beats and out_sat are held stable while out_valid=1 && out_ready=0.
- DONE with out_ready=1: out_valid <= 0 and state <= ACCUM. Output data registers keep their last value.
- Single-beat frame (in_last on the first beat) is legal: out_beats=1.
- Zero-ones frames are legal: out_count=0 with out_valid asserted.
- No combinational path from in_* to out_*. The only combinational path from out_ready is into the state register.
- Saturation never wraps; the count clamps at the all-ones value.

Test Plan:
- Reset mid-frame (WIDTH=8, CNT_W=16): send 8'h0F, 8'h03 without last, pulse rst, then send 8'h01 with last → out_count=1, out_beats=1, out_sat=0. No output appears before the rst pulse.
- Single beat: 8'hFF with last → next cycle out_valid=1, out_count=8, out_beats=1. in_ready=0 until out_ready.
- Multi-beat frame 8'h0F, 8'h01, 8'hFF (last), with 2 idle cycles between beats → out_count=13, out_beats=3, out_sat=0.
- Backpressure: hold out_ready=0 for 5 cycles after the frame 8'hAA (last) → out_valid=1, out_count=4 stable for all 5 cycles, and in_ready=0 throughout. Raise out_ready → next cycle out_valid=0 and in_ready=1.
- Saturation (WIDTH=8, CNT_W=4): 8'hFF, 8'hFF (last) → out_count=15, out_beats=2, out_sat=1. The next frame 8'h01 (last) → out_count=1, out_sat=0.
- WIDTH=1 build: bits 1, 0, 1, 1 (last on the fourth) → out_count=3, out_beats=4. Cross-check every frame against a reference sum computed with $countones on the stimulus.
